// File: rtl/sseg_mux_decoder_pkg.sv
// Shared definitions for the seven-segment bus decoder.
// - SEG_CODES : active-low g..a patterns for hex digits 0..F (same table the
//               encoders use, so both sides agree on every glyph).
// - SEG_BLANK : all segments off.
// - state_t   : acceptance FSM states.
package sseg_mux_decoder_pkg;

    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } state_t;

endpackage

// File: rtl/sseg_to_hex.sv
// Combinational reverse lookup of an active-low 7-segment code.
// Ports:
//   code  in  7  segment lines g..a, active low
//   hit   out 1  code is one of the 16 hex glyphs
//   blank out 1  code is all segments off
//   hex   out 4  decoded value (0 when !hit)
module sseg_to_hex
    import sseg_mux_decoder_pkg::*;
(
    input  logic [6:0] code,
    output logic       hit,
    output logic       blank,
    output logic [3:0] hex
);

    always_comb begin
        hit = 1'b0;
        hex = 4'h0;
        // Table entries are unique, so at most one comparison matches.
        for (int h = 0; h < 16; h++) begin
            if (code == SEG_CODES[h]) begin
                hit = 1'b1;
                hex = 4'(h);
            end
        end
        blank = (code == SEG_BLANK);
    end

endmodule

// File: rtl/sseg_mux_decoder.sv
// Receive-side monitor for a multiplexed active-low seven-segment bus.
// Samples an/sseg, waits for a digit's pattern to be stable for STABLE_CYC
// samples, then decodes it into a per-digit register file.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   an[N_DIG]             anode enables, active low (one low = digit select)
//   sseg[8]               segments, active low, bit 7 = dp
//   hex_out[4*N_DIG]      decoded value per digit (digit i at bits 4i+3:4i)
//   dp_out[N_DIG]         decimal point lit per digit
//   dig_valid[N_DIG]      digit holds a recognised pattern
//   upd                   one-cycle pulse: a digit's stored contents changed
//   err                   one-cycle pulse: stable pattern not decodable
//   idx                   digit index for the last upd/err
module sseg_mux_decoder
    import sseg_mux_decoder_pkg::*;
#(
    parameter int N_DIG      = 4,
    parameter int STABLE_CYC = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_DIG-1:0]         an,
    input  logic [7:0]               sseg,
    output logic [4*N_DIG-1:0]       hex_out,
    output logic [N_DIG-1:0]         dp_out,
    output logic [N_DIG-1:0]         dig_valid,
    output logic                     upd,
    output logic                     err,
    output logic [$clog2(N_DIG)-1:0] idx
);

    localparam int IDX_W = $clog2(N_DIG);
    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int LC_W  = $clog2(N_DIG + 1);

    // Two-stage input synchronizer, parked at "blank, nothing selected".
    logic [N_DIG-1:0] an_s1_reg, an_s2_reg;
    logic [7:0]       sseg_s1_reg, sseg_s2_reg;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    state_t           state_reg, state_next;

    logic [3:0]       hex_reg [N_DIG];
    logic [3:0]       hex_next [N_DIG];
    logic [N_DIG-1:0] dp_reg, dp_next;
    logic [N_DIG-1:0] valid_reg, valid_next;
    logic             upd_reg, upd_next;
    logic             err_reg, err_next;
    logic [IDX_W-1:0] idx_reg, idx_next;

    logic             sample_same;
    logic             sel_ok;
    logic [IDX_W-1:0] dig;
    logic [LC_W-1:0]  low_cnt;
    logic             accept;
    logic             dec_hit, dec_blank;
    logic [3:0]       dec_hex;
    logic             dec_dp;

    // The counter, FSM and decoder look at the sample as it moves into the
    // second synchronizer stage, so their registered results line up with
    // the synchronized sample itself. Acceptance needs the sample to equal
    // its predecessor, so both stages hold the same value at that point.
    assign sample_same = (an_s1_reg == an_s2_reg) && (sseg_s1_reg == sseg_s2_reg);

    always_comb begin
        if (!sample_same) begin
            cnt_next = CNT_W'(1);
        end else if (cnt_reg == CNT_W'(STABLE_CYC)) begin
            cnt_next = cnt_reg;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Exactly-one-low anode detection and index of the low bit.
    always_comb begin
        low_cnt = '0;
        dig     = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (!an_s1_reg[i]) begin
                low_cnt = low_cnt + 1'b1;
                dig     = IDX_W'(i);
            end
        end
        sel_ok = (low_cnt == LC_W'(1));
    end

    sseg_to_hex u_dec (
        .code  (sseg_s1_reg[6:0]),
        .hit   (dec_hit),
        .blank (dec_blank),
        .hex   (dec_hex)
    );

    assign dec_dp = ~sseg_s1_reg[7];

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel_ok) state_next = TRACK;
            end
            TRACK: begin
                if (!sel_ok) begin
                    state_next = IDLE;
                end else if (cnt_next == CNT_W'(STABLE_CYC)) begin
                    accept     = 1'b1;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (!sample_same) state_next = sel_ok ? TRACK : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hex_next   = hex_reg;
        dp_next    = dp_reg;
        valid_next = valid_reg;
        upd_next   = 1'b0;
        err_next   = 1'b0;
        idx_next   = idx_reg;
        if (accept) begin
            if (dec_hit) begin
                hex_next[dig]   = dec_hex;
                dp_next[dig]    = dec_dp;
                valid_next[dig] = 1'b1;
                if (!valid_reg[dig] || (hex_reg[dig] != dec_hex) || (dp_reg[dig] != dec_dp)) begin
                    upd_next = 1'b1;
                    idx_next = dig;
                end
            end else if (dec_blank) begin
                valid_next[dig] = 1'b0;
                if (valid_reg[dig]) begin
                    upd_next = 1'b1;
                    idx_next = dig;
                end
            end else begin
                // Unknown glyph: invalidate but keep the last good value.
                valid_next[dig] = 1'b0;
                err_next        = 1'b1;
                idx_next        = dig;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_s1_reg   <= '1;
            an_s2_reg   <= '1;
            sseg_s1_reg <= '1;
            sseg_s2_reg <= '1;
            cnt_reg     <= '0;
            state_reg   <= IDLE;
            for (int i = 0; i < N_DIG; i++) begin
                hex_reg[i] <= 4'h0;
            end
            dp_reg      <= '0;
            valid_reg   <= '0;
            upd_reg     <= 1'b0;
            err_reg     <= 1'b0;
            idx_reg     <= '0;
        end else begin
            an_s1_reg   <= an;
            an_s2_reg   <= an_s1_reg;
            sseg_s1_reg <= sseg;
            sseg_s2_reg <= sseg_s1_reg;
            cnt_reg     <= cnt_next;
            state_reg   <= state_next;
            hex_reg     <= hex_next;
            dp_reg      <= dp_next;
            valid_reg   <= valid_next;
            upd_reg     <= upd_next;
            err_reg     <= err_next;
            idx_reg     <= idx_next;
        end
    end

    generate
        for (genvar gi = 0; gi < N_DIG; gi++) begin : g_hex_pack
            assign hex_out[4*gi +: 4] = hex_reg[gi];
        end
    endgenerate

    assign dp_out    = dp_reg;
    assign dig_valid = valid_reg;
    assign upd       = upd_reg;
    assign err       = err_reg;
    assign idx       = idx_reg;

endmodule

// File: tb/tb_sseg_mux_decoder.sv
// Directed bench for sseg_mux_decoder with N_DIG=4, STABLE_CYC=4.
module tb_sseg_mux_decoder;
    import sseg_mux_decoder_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [15:0] hex_out;
    logic [3:0]  dp_out;
    logic [3:0]  dig_valid;
    logic        upd;
    logic        err;
    logic [1:0]  idx;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse monitor filled by run()
    int         n_upd;
    int         n_err;
    logic [1:0] upd_log [8];
    logic [1:0] err_idx;

    sseg_mux_decoder #(
        .N_DIG      (4),
        .STABLE_CYC (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .an        (an),
        .sseg      (sseg),
        .hex_out   (hex_out),
        .dp_out    (dp_out),
        .dig_valid (dig_valid),
        .upd       (upd),
        .err       (err),
        .idx       (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-24s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        n_upd   = 0;
        n_err   = 0;
        err_idx = 2'd0;
        for (int i = 0; i < 8; i++) upd_log[i] = 2'd0;
    endtask

    // Advance n clock edges, sampling outputs 1 time unit after each edge.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (upd) begin
                if (n_upd < 8) upd_log[n_upd] = idx;
                n_upd++;
            end
            if (err) begin
                err_idx = idx;
                n_err++;
            end
        end
    endtask

    logic [7:0] rr_seg [4];
    logic [3:0] rr_an  [4];
    logic       rst_activity;

    initial begin
        rr_seg = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
        rr_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Reset held with random bus activity
        reset_n      = 1'b0;
        an           = 4'hF;
        sseg         = 8'hFF;
        rst_activity = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            rst_activity = rst_activity | upd | err | (|hex_out) | (|dp_out) | (|dig_valid) | (|idx);
            an   = 4'($urandom);
            sseg = 8'($urandom);
        end
        check("reset_outputs_quiet", {31'd0, rst_activity}, 32'd0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        an      = 4'hF;
        sseg    = 8'hFF;
        clear_mon();
        run(3);
        check("release_state_idle", dut.state_reg, IDLE);
        check("release_no_pulses", n_upd + n_err, 0);

        // Digit 0 shows "3" with dp lit
        an   = 4'b1110;
        sseg = 8'h30;
        clear_mon();
        run(4);
        check("d0_edge4_no_upd", n_upd, 0);
        check("d0_edge4_valid", dig_valid, 4'b0000);
        run(1);
        check("d0_edge5_upd", upd, 1);
        check("d0_edge5_idx", idx, 0);
        check("d0_hex", hex_out[3:0], 4'h3);
        check("d0_dp", dp_out, 4'b0001);
        check("d0_valid", dig_valid, 4'b0001);
        run(10);
        check("d0_single_upd", n_upd, 1);
        check("d0_no_err", n_err, 0);

        // Digit 1 "2" held only 3 cycles, then the bus goes idle
        an   = 4'b1101;
        sseg = 8'hA4;
        clear_mon();
        run(3);
        an   = 4'hF;
        sseg = 8'hFF;
        run(10);
        check("short_dwell_no_pulse", n_upd + n_err, 0);
        check("short_dwell_valid", dig_valid, 4'b0001);
        check("short_dwell_hex", hex_out, 16'h0003);

        // Digit 2 shows an undecodable glyph
        an   = 4'b1011;
        sseg = 8'hFE;
        clear_mon();
        run(6);
        an   = 4'hF;
        sseg = 8'hFF;
        run(4);
        check("bad_glyph_err_count", n_err, 1);
        check("bad_glyph_err_idx", err_idx, 2);
        check("bad_glyph_no_upd", n_upd, 0);
        check("bad_glyph_valid", dig_valid, 4'b0001);
        check("bad_glyph_hex", hex_out, 16'h0003);

        // Two anodes low, then none low
        an   = 4'b1100;
        sseg = 8'h40;
        clear_mon();
        run(20);
        check("two_low_no_pulse", n_upd + n_err, 0);
        an = 4'b1111;
        run(20);
        check("none_low_no_pulse", n_upd + n_err, 0);
        check("no_sel_valid", dig_valid, 4'b0001);

        // Round robin 1,2,3,4 with dp off, 8-cycle dwell
        clear_mon();
        for (int d = 0; d < 4; d++) begin
            an   = rr_an[d];
            sseg = rr_seg[d];
            run(8);
        end
        check("rr1_upd_count", n_upd, 4);
        check("rr1_err_count", n_err, 0);
        check("rr1_idx_order", {24'd0, upd_log[3], upd_log[2], upd_log[1], upd_log[0]}, 32'b11_10_01_00);
        clear_mon();
        for (int d = 0; d < 4; d++) begin
            an   = rr_an[d];
            sseg = rr_seg[d];
            run(8);
        end
        check("rr2_no_upd", n_upd, 0);
        check("rr2_no_err", n_err, 0);
        check("rr_hex", hex_out, 16'h4321);
        check("rr_valid", dig_valid, 4'hF);
        check("rr_dp", dp_out, 4'h0);

        // Blank digit 1
        an   = 4'b1101;
        sseg = 8'hFF;
        clear_mon();
        run(8);
        check("blank_upd_count", n_upd, 1);
        check("blank_upd_idx", upd_log[0], 1);
        check("blank_no_err", n_err, 0);
        check("blank_valid", dig_valid, 4'b1101);
        check("blank_hex_kept", hex_out, 16'h4321);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sseg_mux_decoder.md
# sseg_mux_decoder

Receive-side monitor for the time-multiplexed, active-low seven-segment display bus (anode enables plus 8-bit segment/dp lines) that our hex-to-segment encoders and display multiplexers drive. It samples the bus, waits for each digit's pattern to be stable, and decodes it back to a 4-bit hex value and a dp flag. It holds a per-digit register file of the result. It sits in self-checking benches and loopback debug designs, on the same pins the display multiplexer drives.

## Interface
- N_DIG, 4: number of multiplexed digits (2..8).
- STABLE_CYC, 16: consecutive identical synchronized samples required before a pattern is accepted (≥2).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- an  in  N_DIG  anode enables, active low; exactly one low selects a digit.
- sseg  in  8  segments, active low; bit 7 = dp, bits 6:0 = g..a.
- hex_out  out  4*N_DIG  decoded value; digit i occupies bits 4i+3:4i.
- dp_out  out  N_DIG  decimal point lit (active high, = ~sseg[7] at acceptance).
- dig_valid  out  N_DIG  digit holds a recognised pattern.
- upd  out  1  one-cycle pulse: a digit's stored value/dp/valid changed.
- err  out  1  one-cycle pulse: stable pattern not in the decode set.
- idx  out  clog2(N_DIG)  digit index for upd/err; held otherwise.

## Operation
- an and sseg pass through a 2-flop synchronizer; the synchronizer resets to all-ones (blank).
- sel_ok is true when exactly one bit of the synchronized an is low. dig is the index of that bit.
- The stability counter (width clog2(STABLE_CYC+1)) runs on the {an, sseg} sample:
  - sample == previous sample: increment, saturating at STABLE_CYC.
  - otherwise: load 1.
- FSM states:
  - IDLE: waits for sel_ok. On sel_ok, go to TRACK.
  - TRACK: if !sel_ok, go to IDLE. When the counter reaches STABLE_CYC, perform one acceptance and go to HELD.
  - HELD: no further acceptance. A sample change goes to TRACK, or to IDLE if !sel_ok.
- Acceptance (one digit, one cycle):
  - Segment code is one of the 16 encoder codes (0x40,0x79,0x24,0x30,0x19,0x12,0x02,0x78,0x00,0x10,0x08,0x03,0x46,0x21,0x06,0x0E for 0..F): write hex_out[dig] and dp_out[dig], set dig_valid[dig]. Pulse upd with idx=dig only if the value, dp or valid bit differs from what was stored.
  - Segment code is 0x7F (blank): clear dig_valid[dig]. Pulse upd if the bit was set. No err.
  - Any other code: clear dig_valid[dig], leave hex_out and dp_out unchanged, pulse err with idx=dig.
- upd and err are mutually exclusive.
- Reset: all outputs 0, state IDLE, counter 0. Reset asserted mid-acceptance discards that acceptance.

## Timing
- Edge 1 is the first edge at which new input is sampled. The synchronized sample changes at edge 2.
- The acceptance registers update at edge STABLE_CYC+1. upd/err are high for the cycle after that edge.
- A change before the STABLE_CYC-th identical sample produces no update.
- A dwell shorter than STABLE_CYC+2 cycles per digit may be missed; this is required glitch rejection.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - the 16-entry active-low segment code constants, shared with the encoder side;
  - the BLANK code 7'h7F;
  - the FSM state typedef {IDLE, TRACK, HELD}.
- Sub-module sseg_to_hex: combinational 7-bit code to {hit, blank, hex[3:0]}, instantiated once.

## Test plan
All scenarios use N_DIG=4, STABLE_CYC=4.
- Reset: hold reset_n low with random bus activity -> all outputs 0, no pulses. Release -> state IDLE.
- Hold an=4'b1110, sseg=8'h30 ("3", dp lit) -> at edge 5: hex_out[3:0]=3, dp_out[0]=1, dig_valid=4'b0001, single upd with idx=0. Further holding produces no pulse.
- Hold an=4'b1101, sseg=8'hA4 for 3 cycles, then change the pattern -> no upd, dig_valid unchanged.
- Hold an=4'b1011, sseg=8'hFE for 6 cycles -> single err with idx=2, dig_valid[2]=0, hex_out unchanged.
- an=4'b1100 (two low) for 20 cycles -> no acceptance, no pulses. an=4'b1111 behaves the same.
- Round-robin digits 0..3 showing 1,2,3,4 (dp off), 8-cycle dwell, two rounds -> hex_out=16'h4321, dig_valid=4'hF. Four upd pulses (idx 0,1,2,3) in round one, none in round two. Then blank digit 1 (0xFF) -> one upd with idx=1, dig_valid=4'b1101, no err.
